// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LDR = 1'b1;

  // Width of the latency and starvation counters (both legal up to 15).
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/arb_pick2.sv
// Two-way picker: core wins ties unless the loader has lost STARVE_MAX times.
module arb_pick2
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic update,
  output logic grant
);

  logic [CNT_W-1:0] starve_cnt;

  // Grant 1 (loader) when it is alone or has been starved long enough.
  always_comb begin
    grant = req1 & (~req0 | (starve_cnt == CNT_W'(STARVE_MAX)));
  end

  // Count loader losses; clear on a loader win, saturate at STARVE_MAX.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (update) begin
      if (grant) begin
        starve_cnt <= '0;
      end else if (req1 && (starve_cnt != CNT_W'(STARVE_MAX))) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory between the core (port 0) and the loader (port 1),
// sequencing each access as ISSUE / WAIT / RESP.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_ack,
  output logic [DW-1:0] ldr_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner
);

  arb_state_t       state;
  logic [CNT_W-1:0] lat_cnt;
  logic             lat_we;
  logic [DW-1:0]    cpu_hold;
  logic [DW-1:0]    ldr_hold;
  logic             any_req;
  logic             grant;

  assign any_req = cpu_req | ldr_req;

  arb_pick2 #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .clk   (clk),
    .reset (reset),
    .req0  (cpu_req),
    .req1  (ldr_req),
    .update((state == IDLE) & any_req),
    .grant (grant)
  );

  // Access sequencer; mem_addr/mem_wdata double as the request latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= OWN_CPU;
      lat_we    <= 1'b0;
      lat_cnt   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_ack   <= 1'b0;
      ldr_ack   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= grant;
            lat_we    <= grant ? ldr_we : cpu_we;
            mem_we    <= grant ? ldr_we : cpu_we;
            mem_addr  <= grant ? ldr_addr : cpu_addr;
            mem_wdata <= grant ? ldr_wdata : cpu_wdata;
            mem_en    <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          lat_cnt <= CNT_W'(MEM_LAT - 1);
          if (MEM_LAT == 1) begin
            cpu_ack <= (owner == OWN_CPU);
            ldr_ack <= (owner == OWN_LDR);
            state   <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == CNT_W'(1)) begin
            cpu_ack <= (owner == OWN_CPU);
            ldr_ack <= (owner == OWN_LDR);
            state   <= RESP;
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          cpu_ack <= 1'b0;
          ldr_ack <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Capture read data into the owner's hold register during RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_hold <= '0;
      ldr_hold <= '0;
    end else if ((state == RESP) && !lat_we) begin
      if (owner == OWN_LDR) begin
        ldr_hold <= mem_rdata;
      end else begin
        cpu_hold <= mem_rdata;
      end
    end
  end

  // Read data passes straight through in the ack cycle, else shows the hold reg.
  assign cpu_rdata = (cpu_ack && !lat_we) ? mem_rdata : cpu_hold;
  assign ldr_rdata = (ldr_ack && !lat_we) ? mem_rdata : ldr_hold;

  // Stall is forced low while reset is asserted so every output reads 0 in reset.
  assign cpu_stall = cpu_req & ~cpu_ack & ~reset;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a vector table on a MEM_LAT=1 instance plus hand
// sequences on a MEM_LAT=3 / STARVE_MAX=4 instance.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance A: MEM_LAT=1, STARVE_MAX=8
  logic        a_reset, a_creq, a_cwe, a_cack, a_cstall;
  logic        a_lreq, a_lwe, a_lack, a_men, a_mwe, a_own;
  logic [31:0] a_caddr, a_cwdata, a_crdata, a_laddr, a_lwdata, a_lrdata;
  logic [31:0] a_maddr, a_mwdata, a_mrdata;

  // Instance B: MEM_LAT=3, STARVE_MAX=4
  logic        b_reset, b_creq, b_cwe, b_cack, b_cstall;
  logic        b_lreq, b_lwe, b_lack, b_men, b_mwe, b_own;
  logic [31:0] b_caddr, b_cwdata, b_crdata, b_laddr, b_lwdata, b_lrdata;
  logic [31:0] b_maddr, b_mwdata, b_mrdata;

  logic [133:0] a_out, b_out;
  assign a_out = {a_men, a_mwe, a_maddr, a_mwdata, a_cack, a_crdata, a_cstall,
                  a_lack, a_lrdata, a_own};
  assign b_out = {b_men, b_mwe, b_maddr, b_mwdata, b_cack, b_crdata, b_cstall,
                  b_lack, b_lrdata, b_own};

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(8)) dut_a (
    .clk(clk), .reset(a_reset),
    .cpu_req(a_creq), .cpu_we(a_cwe), .cpu_addr(a_caddr), .cpu_wdata(a_cwdata),
    .cpu_ack(a_cack), .cpu_rdata(a_crdata), .cpu_stall(a_cstall),
    .ldr_req(a_lreq), .ldr_we(a_lwe), .ldr_addr(a_laddr), .ldr_wdata(a_lwdata),
    .ldr_ack(a_lack), .ldr_rdata(a_lrdata),
    .mem_en(a_men), .mem_we(a_mwe), .mem_addr(a_maddr), .mem_wdata(a_mwdata),
    .mem_rdata(a_mrdata), .owner(a_own)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .STARVE_MAX(4)) dut_b (
    .clk(clk), .reset(b_reset),
    .cpu_req(b_creq), .cpu_we(b_cwe), .cpu_addr(b_caddr), .cpu_wdata(b_cwdata),
    .cpu_ack(b_cack), .cpu_rdata(b_crdata), .cpu_stall(b_cstall),
    .ldr_req(b_lreq), .ldr_we(b_lwe), .ldr_addr(b_laddr), .ldr_wdata(b_lwdata),
    .ldr_ack(b_lack), .ldr_rdata(b_lrdata),
    .mem_en(b_men), .mem_we(b_mwe), .mem_addr(b_maddr), .mem_wdata(b_mwdata),
    .mem_rdata(b_mrdata), .owner(b_own)
  );

  typedef struct {
    logic         creq, cwe;
    logic [31:0]  caddr, cwdata;
    logic         lreq, lwe;
    logic [31:0]  laddr, lwdata, mrdata;
    logic [133:0] exp;
    logic [3:0]   starve;
  } vec_t;

  vec_t vt[16];

  function automatic vec_t mk(
    input logic creq, input logic cwe, input logic [31:0] caddr, input logic [31:0] cwdata,
    input logic lreq, input logic lwe, input logic [31:0] laddr, input logic [31:0] lwdata,
    input logic [31:0] mrdata,
    input logic men, input logic mwe, input logic [31:0] maddr, input logic [31:0] mwdata,
    input logic cack, input logic [31:0] crdata, input logic cstall,
    input logic lack, input logic [31:0] lrdata, input logic own, input logic [3:0] starve);
    vec_t v;
    v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwdata = cwdata;
    v.lreq = lreq; v.lwe = lwe; v.laddr = laddr; v.lwdata = lwdata; v.mrdata = mrdata;
    v.exp = {men, mwe, maddr, mwdata, cack, crdata, cstall, lack, lrdata, own};
    v.starve = starve;
    return v;
  endfunction

  task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // inputs: creq cwe caddr cwdata lreq lwe laddr lwdata mrdata
    // expect: men mwe maddr mwdata cack crdata cstall lack lrdata own starve
    vt[0]  = mk(1,0,32'h10,0, 0,0,0,0, 32'hDEADBEEF, 1,0,32'h10,0, 0,0,1, 0,0,0, 0);
    vt[1]  = mk(1,0,32'h10,0, 0,0,0,0, 32'hDEADBEEF, 0,0,32'h10,0, 1,32'hDEADBEEF,0, 0,0,0, 0);
    vt[2]  = mk(0,0,0,0, 0,0,0,0, 32'hDEADBEEF,      0,0,32'h10,0, 0,32'hDEADBEEF,0, 0,0,0, 0);
    vt[3]  = mk(0,0,0,0, 0,0,0,0, 32'h0BADF00D,      0,0,32'h10,0, 0,32'hDEADBEEF,0, 0,0,0, 0);
    vt[4]  = mk(1,0,32'h20,0, 1,0,32'h30,0, 32'h11111111, 1,0,32'h20,0, 0,32'hDEADBEEF,1, 0,0,0, 1);
    vt[5]  = mk(1,0,32'h20,0, 1,0,32'h30,0, 32'h11111111, 0,0,32'h20,0, 1,32'h11111111,0, 0,0,0, 1);
    vt[6]  = mk(0,0,0,0, 1,0,32'h30,0, 32'h11111111, 0,0,32'h20,0, 0,32'h11111111,0, 0,0,0, 1);
    vt[7]  = mk(0,0,0,0, 1,0,32'h30,0, 32'h22222222, 1,0,32'h30,0, 0,32'h11111111,0, 0,0,1, 0);
    vt[8]  = mk(0,0,0,0, 1,0,32'h30,0, 32'h22222222, 0,0,32'h30,0, 0,32'h11111111,0, 1,32'h22222222,1, 0);
    vt[9]  = mk(0,0,0,0, 0,0,0,0, 32'h22222222,      0,0,32'h30,0, 0,32'h11111111,0, 0,32'h22222222,1, 0);
    vt[10] = mk(0,0,0,0, 1,1,32'h40,32'h12345678, 32'h33333333,
                1,1,32'h40,32'h12345678, 0,32'h11111111,0, 0,32'h22222222,1, 0);
    vt[11] = mk(0,0,0,0, 1,1,32'h40,32'h12345678, 32'h33333333,
                0,0,32'h40,32'h12345678, 0,32'h11111111,0, 1,32'h22222222,1, 0);
    vt[12] = mk(0,0,0,0, 0,0,0,0, 32'h33333333,
                0,0,32'h40,32'h12345678, 0,32'h11111111,0, 0,32'h22222222,1, 0);
    vt[13] = mk(1,1,32'h44,32'hCAFEF00D, 0,0,0,0, 32'h44444444,
                1,1,32'h44,32'hCAFEF00D, 0,32'h11111111,1, 0,32'h22222222,0, 0);
    vt[14] = mk(1,1,32'h44,32'hCAFEF00D, 0,0,0,0, 32'h44444444,
                0,0,32'h44,32'hCAFEF00D, 1,32'h11111111,0, 0,32'h22222222,0, 0);
    vt[15] = mk(0,0,0,0, 0,0,0,0, 32'h44444444,
                0,0,32'h44,32'hCAFEF00D, 0,32'h11111111,0, 0,32'h22222222,0, 0);

    a_reset = 1; a_creq = 0; a_cwe = 0; a_caddr = 0; a_cwdata = 0;
    a_lreq = 0; a_lwe = 0; a_laddr = 0; a_lwdata = 0; a_mrdata = 0;
    b_reset = 1; b_creq = 0; b_cwe = 0; b_caddr = 0; b_cwdata = 0;
    b_lreq = 0; b_lwe = 0; b_laddr = 0; b_lwdata = 0; b_mrdata = 0;
    tick(); tick();
    check("a_reset_outs", a_out, '0);
    a_reset = 0;
    tick();

    // Stall is visible combinationally in the request cycle itself.
    a_creq = 1; a_caddr = 32'h10; a_mrdata = 32'hDEADBEEF;
    #1;
    check("a_stall_T", 134'(a_cstall), 134'(1));

    for (int i = 0; i < 16; i++) begin
      a_creq = vt[i].creq; a_cwe = vt[i].cwe; a_caddr = vt[i].caddr; a_cwdata = vt[i].cwdata;
      a_lreq = vt[i].lreq; a_lwe = vt[i].lwe; a_laddr = vt[i].laddr; a_lwdata = vt[i].lwdata;
      a_mrdata = vt[i].mrdata;
      tick();
      check($sformatf("vec%0d", i), a_out, vt[i].exp);
      check($sformatf("vec%0d_starve", i), 134'(dut_a.u_pick.starve_cnt), 134'(vt[i].starve));
    end

    // Instance B: reset state, then starvation with both requests held.
    b_reset = 0;
    check("b_reset_outs", b_out, '0);
    tick();
    b_creq = 1; b_caddr = 32'h100; b_lreq = 1; b_laddr = 32'h200; b_mrdata = 32'h77777777;
    for (int k = 0; k < 6; k++) begin
      bit seen = 0;
      logic exp_own = (k == 4) ? 1'b1 : 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        tick();
        if (b_men) seen = 1;
      end
      if (!seen) begin
        tests++; fails++;
        $display("FAIL starve_grant%0d: no mem_en within 20 cycles, want one", k);
      end else begin
        check($sformatf("starve_grant%0d_owner", k), 134'(b_own), 134'(exp_own));
      end
    end
    b_creq = 0; b_lreq = 0;
    repeat (8) tick();

    // Reset during WAIT aborts the access; a following read has normal latency.
    b_creq = 1; b_caddr = 32'h50; b_mrdata = 32'h55555555;
    tick();
    check("rst_issue_men", 134'(b_men), 134'(1));
    tick();
    b_reset = 1;
    tick();
    check("rst_all_zero", b_out, '0);
    b_reset = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("rst_after_cyc%0d_en_ack", k), 134'({b_men, b_cack}),
            134'({(k == 1), (k == 4)}));
      if (k == 4) check("rst_after_rdata", 134'(b_crdata), 134'(32'h55555555));
    end
    b_creq = 0;
    tick(); tick();

    // Request dropped during WAIT: access still completes with one ack.
    begin
      int acks = 0;
      int ens  = 0;
      b_creq = 1; b_caddr = 32'h60; b_mrdata = 32'h66666666;
      tick();
      check("drop_issue_men", 134'(b_men), 134'(1));
      tick();
      b_creq = 0;
      for (int c = 0; c < 8; c++) begin
        tick();
        if (b_cack) acks++;
        if (b_men) ens++;
      end
      check("drop_ack_count", 134'(acks), 134'(1));
      check("drop_no_mem_en", 134'(ens), 134'(0));
      check("drop_hold_rdata", 134'(b_crdata), 134'(32'h66666666));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
